// File: rtl/lc3_dmem_responder_pkg.sv
//------------------------------------------------------------------------------
// dmem_pkg_hdl : shared types and constants for the LC3 data-memory responder
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg_hdl;

  localparam int DMEM_DATA_W     = 16;
  localparam int DMEM_ADDR_BUS_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  typedef logic [DMEM_DATA_W-1:0] dmem_word_t;

endpackage

`default_nettype wire

// File: rtl/dmem_sram_1p.sv
//------------------------------------------------------------------------------
// dmem_sram_1p : single-port synchronous word array, registered read, no reset
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_sram_1p #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/lc3_dmem_responder.sv
//------------------------------------------------------------------------------
// lc3_dmem_responder : data-memory slave with programmable wait states
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lc3_dmem_responder
  import dmem_pkg_hdl::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2,
  parameter int STRICT  = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       Data_en,
  input  logic                       Data_rd,
  input  logic [DMEM_ADDR_BUS_W-1:0] Data_addr,
  input  logic [DATA_W-1:0]          Data_din,
  output logic [DATA_W-1:0]          Data_dout,
  output logic                       complete_data,
  output logic                       busy,
  output logic                       addr_err
);

  localparam bit         HAS_WAIT = (LATENCY > 0);
  localparam logic [3:0] LAT_M1   = HAS_WAIT ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_t       state, state_next;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] dout_q;
  logic              rd_q;
  logic              err_q;
  logic              accept;
  logic              upper_nz;
  logic              read_done;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  generate
    if (STRICT != 0 && ADDR_W < DMEM_ADDR_BUS_W) begin : g_strict
      assign upper_nz = |Data_addr[DMEM_ADDR_BUS_W-1:ADDR_W];
    end else begin : g_alias
      logic unused_upper;
      assign unused_upper = ^Data_addr;
      assign upper_nz     = 1'b0;
    end
  endgenerate

  assign accept    = (state == IDLE) && Data_en;
  assign read_done = (state == DONE) && rd_q && !err_q;
  assign ram_we    = (state == DONE) && !rd_q && !err_q;
  // Address the array from the live bus in IDLE so a zero-latency read has data on entering DONE.
  assign ram_addr  = (state == IDLE) ? Data_addr[ADDR_W-1:0] : addr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Data_en) begin
          state_next = HAS_WAIT ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= 4'd0;
      addr_q <= '0;
      din_q  <= '0;
      rd_q   <= 1'b0;
      err_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= Data_addr[ADDR_W-1:0];
        din_q  <= Data_din;
        rd_q   <= Data_rd;
        err_q  <= upper_nz;
        cnt    <= LAT_M1;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (read_done) begin
        dout_q <= ram_rdata;
      end
    end
  end

  assign Data_dout     = read_done ? ram_rdata : dout_q;
  assign complete_data = (state == DONE) && !err_q;
  assign addr_err      = (state == DONE) && err_q;
  assign busy          = (state != IDLE);

  dmem_sram_1p #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_sram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (din_q),
    .rdata (ram_rdata)
  );

endmodule

`default_nettype wire
